// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants, types and the busy-scoreboard update rule for the writeback scheduler.
// Purely declarative, with no latency and no flow control of its own.
package regfile_wb_scheduler_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic GNT_EX = 1'b0;
  localparam logic GNT_LD = 1'b1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_COUNT-1:0]  busy_vec_t;

  // Clear from the retiring write first, then set from the new reservation,
  // so a same-edge collision leaves the register busy for the newer instruction.
  function automatic busy_vec_t busy_next(
    input busy_vec_t cur,
    input logic      clr_en,
    input reg_addr_t clr_rd,
    input logic      set_en,
    input reg_addr_t set_rd
  );
    busy_vec_t nxt;
    nxt = cur;
    if (clr_en) nxt[clr_rd] = 1'b0;
    if (set_en && (set_rd != '0)) nxt[set_rd] = 1'b1;
    nxt[0] = 1'b0;
    return nxt;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_arb.sv
// Two-way round-robin arbiter (ex/ld) with its last-grant pointer; grants are combinational.
// A grant is the transfer, so the pointer advances on every grant and nothing is ever held.
module wb_rr_arbiter2
  import regfile_wb_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ex_req,
  input  logic ld_req,
  output logic ex_gnt,
  output logic ld_gnt
);

  logic last;

  // Grants are masked while reset is held so nothing is accepted into a clearing pipeline.
  always_comb begin
    ex_gnt = rst & ex_req & (~ld_req | (last == GNT_LD));
    ld_gnt = rst & ld_req & (~ex_req | (last == GNT_EX));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= GNT_LD;
    end else if (ex_gnt) begin
      last <= GNT_EX;
    end else if (ld_gnt) begin
      last <= GNT_LD;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: round-robin ex/ld onto one write port plus a busy scoreboard.
// Latency 1 cycle (accept -> wb_*); the output stage never stalls, so a requester waits at most one cycle.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [WORD_SIZE-1:0]  ex_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [WORD_SIZE-1:0]  ld_data,
  input  logic                  rsv_en,
  input  logic [REG_ADDR_W-1:0] rsv_rd,
  input  logic [REG_ADDR_W-1:0] q_rs1,
  input  logic [REG_ADDR_W-1:0] q_rs2,
  output logic                  busy_rs1,
  output logic                  busy_rs2,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [WORD_SIZE-1:0]  wb_data
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WORD_SIZE-1:0]  data;
  } wb_req_t;

  logic      ex_gnt;
  logic      ld_gnt;
  logic      xfer;
  wb_req_t   sel;
  busy_vec_t busy;

  wb_rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .ex_req (ex_valid),
    .ld_req (ld_valid),
    .ex_gnt (ex_gnt),
    .ld_gnt (ld_gnt)
  );

  assign ex_ready = ex_gnt;
  assign ld_ready = ld_gnt;
  assign xfer     = ex_gnt | ld_gnt;

  always_comb begin
    sel = '{rd: ex_rd, data: ex_data};
    if (ld_gnt) sel = '{rd: ld_rd, data: ld_data};
  end

  // Writes to x0 are accepted but never reach the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      wb_en <= xfer && (sel.rd != '0);
      if (xfer) begin
        wb_rd   <= sel.rd;
        wb_data <= sel.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next(busy, wb_en, wb_rd, rsv_en, rsv_rd);
    end
  end

  assign busy_rs1 = busy[q_rs1];
  assign busy_rs2 = busy[q_rs2];

  a_one_ready: assert property (@(posedge clk) disable iff (!rst) !(ex_ready && ld_ready));
  a_x0_idle:   assert property (@(posedge clk) disable iff (!rst) !busy[0]);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;
  import regfile_wb_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0, ld_valid = 1'b0, rsv_en = 1'b0;
  logic        ex_ready, ld_ready, busy_rs1, busy_rs2, wb_en;
  logic [4:0]  ex_rd = '0, ld_rd = '0, rsv_rd = '0, q_rs1 = '0, q_rs2 = '0, wb_rd;
  logic [31:0] ex_data = '0, ld_data = '0, wb_data;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.WORD_SIZE(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rsv_en(rsv_en), .rsv_rd(rsv_rd), .q_rs1(q_rs1), .q_rs2(q_rs2),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every register-file write must match the next expected entry.
  always @(negedge clk) begin
    if (rst && wb_en) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", {27'd0, wb_rd}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_data", wb_data, e.data);
      end
    end
  end

  initial begin
    int ei, li;
    // Reset held with both requesters valid.
    ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'hA;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'hB;
    step(); step();
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_busy", {30'd0, busy_rs1, busy_rs2}, 32'd0);

    rst = 1'b1;
    #1;
    chk("first_tie_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("first_tie_ld_ready", {31'd0, ld_ready}, 32'd0);
    exp_q.push_back('{rd: 5'd3, data: 32'hA});
    step();
    ex_valid = 1'b0;
    #1;
    chk("ld_alone_ready", {31'd0, ld_ready}, 32'd1);
    exp_q.push_back('{rd: 5'd4, data: 32'hB});
    step();
    ld_valid = 1'b0;
    step();

    // Continuous dual requests alternate ex, ld, ...
    ei = 0; li = 0;
    ex_valid = 1'b1; ex_rd = 5'd10; ex_data = 32'h100;
    ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'h200;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("alt_ex_ready", {31'd0, ex_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_ld_ready", {31'd0, ld_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i % 2 == 0) exp_q.push_back('{rd: ex_rd, data: ex_data});
      else            exp_q.push_back('{rd: ld_rd, data: ld_data});
      step();
      chk("alt_wb_en", {31'd0, wb_en}, 32'd1);
      if (i % 2 == 0) begin
        ei++; ex_rd = 5'(10 + ei); ex_data = 32'h100 + ei;
      end else begin
        li++; ld_rd = 5'(20 + li); ld_data = 32'h200 + li;
      end
    end
    ex_valid = 1'b0; ld_valid = 1'b0;
    step();

    // Reserve x7, then retire it through the load port.
    q_rs1 = 5'd7;
    rsv_en = 1'b1; rsv_rd = 5'd7;
    #1;
    chk("rsv7_before", {31'd0, busy_rs1}, 32'd0);
    step();
    rsv_en = 1'b0;
    chk("rsv7_busy", {31'd0, busy_rs1}, 32'd1);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
    exp_q.push_back('{rd: 5'd7, data: 32'h77});
    step();
    ld_valid = 1'b0;
    chk("wb7_en", {31'd0, wb_en}, 32'd1);
    chk("wb7_still_busy", {31'd0, busy_rs1}, 32'd1);
    step();
    chk("wb7_cleared", {31'd0, busy_rs1}, 32'd0);

    // Same-edge set and clear of x9: the reservation wins.
    q_rs2 = 5'd9;
    rsv_en = 1'b1; rsv_rd = 5'd9;
    step();
    rsv_en = 1'b0;
    ex_valid = 1'b1; ex_rd = 5'd9; ex_data = 32'h99;
    exp_q.push_back('{rd: 5'd9, data: 32'h99});
    step();
    ex_valid = 1'b0;
    rsv_en = 1'b1; rsv_rd = 5'd9;
    chk("x9_wb_en", {31'd0, wb_en}, 32'd1);
    step();
    rsv_en = 1'b0;
    chk("x9_set_wins", {31'd0, busy_rs2}, 32'd1);
    step();
    chk("x9_stays", {31'd0, busy_rs2}, 32'd1);

    // x0 writes are accepted then dropped; x0 never becomes busy.
    ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'hDEAD;
    #1;
    chk("x0_ready", {31'd0, ex_ready}, 32'd1);
    step();
    ex_valid = 1'b0;
    chk("x0_wb_en", {31'd0, wb_en}, 32'd0);
    q_rs1 = 5'd0;
    rsv_en = 1'b1; rsv_rd = 5'd0;
    step();
    rsv_en = 1'b0;
    chk("x0_not_busy", {31'd0, busy_rs1}, 32'd0);

    // Reset mid-operation with a write in flight and x5 busy.
    q_rs1 = 5'd5;
    rsv_en = 1'b1; rsv_rd = 5'd5;
    step();
    rsv_en = 1'b0;
    chk("x5_busy", {31'd0, busy_rs1}, 32'd1);
    ex_valid = 1'b1; ex_rd = 5'd12; ex_data = 32'hC12;
    exp_q.push_back('{rd: 5'd12, data: 32'hC12});
    step();
    ex_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_wb_en", {31'd0, wb_en}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("midrst_busy5", {31'd0, busy_rs1}, 32'd0);
    step();
    ex_valid = 1'b1; ex_rd = 5'd13; ex_data = 32'hE13;
    ld_valid = 1'b1; ld_rd = 5'd14; ld_data = 32'hF14;
    rst = 1'b1;
    #1;
    chk("post_rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("post_rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    exp_q.push_back('{rd: 5'd13, data: 32'hE13});
    step();
    ex_valid = 1'b0;
    exp_q.push_back('{rd: 5'd14, data: 32'hF14});
    step();
    ld_valid = 1'b0;
    step(); step();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
